// File: rtl/dht11_frame_rx.sv
// DHT11 single-wire host receiver: start pulse, response/bit timing, 40-bit frame capture.
// Define DHT11_CHECKSUM_EN to reject frames whose checksum byte does not match.
module dht11_frame_rx #(
   parameter int CLK_MHZ        = 50,
   parameter int START_LOW_US   = 18000,
   parameter int TIMEOUT_US     = 200,
   parameter int BIT1_THRESH_US = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       data,
   output logic       data_oe,
   output logic       busy,
   output logic       valid,
   output logic [7:0] hum_int,
   output logic [7:0] hum_dec,
   output logic [7:0] temp_int,
   output logic [7:0] temp_dec,
   output logic       err,
   output logic [1:0] err_code
);
   localparam int              PW        = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
   localparam logic [PW-1:0]   PRE_LAST  = PW'(CLK_MHZ - 1);
   localparam logic [14:0]     US_MAX    = 15'h7fff;
   localparam logic [14:0]     START_US  = 15'(START_LOW_US);
   localparam logic [14:0]     TMO_US    = 15'(TIMEOUT_US);
   localparam logic [14:0]     THRESH_US = 15'(BIT1_THRESH_US);

   typedef enum logic [2:0] {
      S_IDLE, S_START_LOW, S_WAIT_RESP, S_RESP_LOW,
      S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_CHECK
   } state_t;

`ifdef DHT11_CHECKSUM_EN
   function automatic logic [7:0] checksum8(input logic [31:0] b);
      return b[31:24] + b[23:16] + b[15:8] + b[7:0];
   endfunction
`endif

   state_t        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic          prev_q, prev_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [14:0]   us_q, us_d;
   logic [5:0]    bit_cnt_q, bit_cnt_d;
   logic [39:0]   shift_q, shift_d;
   logic [31:0]   bytes_q, bytes_d;
   logic          data_oe_q, data_oe_d;
   logic          busy_q, busy_d;
   logic          valid_q, valid_d;
   logic          err_q, err_d;
   logic [1:0]    err_code_q, err_code_d;

   logic          rise_s, fall_s, tick_s, tmo_s, frame_ok_s;
   logic [14:0]   us_now_s;

   // Next-state and next-output computation for the whole receiver.
   always_comb begin
      rise_s   = sync_q[1] & ~prev_q;
      fall_s   = ~sync_q[1] & prev_q;
      tick_s   = (pre_q == PRE_LAST);
      // Elapsed whole microseconds including the current cycle.
      us_now_s = (tick_s && (us_q != US_MAX)) ? us_q + 15'd1 : us_q;
      tmo_s    = (us_now_s >= TMO_US);
`ifdef DHT11_CHECKSUM_EN
      frame_ok_s = (shift_q[7:0] == checksum8(shift_q[39:8]));
`else
      frame_ok_s = 1'b1;
`endif

      sync_d     = {sync_q[0], data};
      prev_d     = sync_q[1];
      state_d    = state_q;
      pre_d      = tick_s ? '0 : pre_q + PW'(1);
      us_d       = us_now_s;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      bytes_d    = bytes_q;
      data_oe_d  = data_oe_q;
      busy_d     = busy_q;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d    = S_START_LOW;
               data_oe_d  = 1'b1;
               busy_d     = 1'b1;
               err_code_d = 2'd0;
               bit_cnt_d  = 6'd0;
            end else begin
               data_oe_d = 1'b0;
            end
         end
         S_START_LOW: begin
            if (us_now_s == START_US) begin
               state_d   = S_WAIT_RESP;
               data_oe_d = 1'b0;
            end else begin
               data_oe_d = 1'b1;
            end
         end
         S_WAIT_RESP: begin
            if (fall_s) begin
               state_d = S_RESP_LOW;
            end else if (tmo_s) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               err_d      = 1'b1;
               err_code_d = 2'd1;
            end else begin
               state_d = S_WAIT_RESP;
            end
         end
         S_RESP_LOW, S_BIT_LOW: begin
            if (rise_s) begin
               state_d = (state_q == S_RESP_LOW) ? S_RESP_HIGH : S_BIT_HIGH;
            end else if (tmo_s) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               err_d      = 1'b1;
               err_code_d = 2'd3;
            end else begin
               state_d = state_q;
            end
         end
         S_RESP_HIGH: begin
            if (fall_s) begin
               state_d = S_BIT_LOW;
            end else if (tmo_s) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               err_d      = 1'b1;
               err_code_d = 2'd3;
            end else begin
               state_d = S_RESP_HIGH;
            end
         end
         S_BIT_HIGH: begin
            if (fall_s) begin
               shift_d   = {shift_q[38:0], (us_now_s > THRESH_US)};
               bit_cnt_d = bit_cnt_q + 6'd1;
               state_d   = (bit_cnt_q == 6'd39) ? S_CHECK : S_BIT_LOW;
            end else if (tmo_s) begin
               state_d    = S_IDLE;
               busy_d     = 1'b0;
               err_d      = 1'b1;
               err_code_d = 2'd3;
            end else begin
               state_d = S_BIT_HIGH;
            end
         end
         S_CHECK: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            if (frame_ok_s) begin
               valid_d = 1'b1;
               bytes_d = shift_q[39:8];
            end else begin
               err_d      = 1'b1;
               err_code_d = 2'd2;
            end
         end
         default: begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            data_oe_d = 1'b0;
         end
      endcase

      // The microsecond timebase restarts on every state entry.
      if (state_d != state_q) begin
         pre_d = '0;
         us_d  = 15'd0;
      end else begin
         us_d = us_now_s;
      end
   end

   // State and output registers; rst returns everything to idle values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         sync_q     <= 2'b11;
         prev_q     <= 1'b1;
         pre_q      <= '0;
         us_q       <= 15'd0;
         bit_cnt_q  <= 6'd0;
         shift_q    <= 40'd0;
         bytes_q    <= 32'd0;
         data_oe_q  <= 1'b0;
         busy_q     <= 1'b0;
         valid_q    <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         prev_q     <= prev_d;
         pre_q      <= pre_d;
         us_q       <= us_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         bytes_q    <= bytes_d;
         data_oe_q  <= data_oe_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
      end
   end

   assign data_oe  = data_oe_q;
   assign busy     = busy_q;
   assign valid    = valid_q;
   assign err      = err_q;
   assign err_code = err_code_q;
   assign hum_int  = bytes_q[31:24];
   assign hum_dec  = bytes_q[23:16];
   assign temp_int = bytes_q[15:8];
   assign temp_dec = bytes_q[7:0];

endmodule

// File: tb/tb_dht11_frame_rx.sv
// Bench for dht11_frame_rx: a DHT11 sensor model drives the line, a time-window model predicts every output.
`timescale 1ns/1ps
module tb_dht11_frame_rx;
   localparam int CLK_MHZ        = 2;
   localparam int START_LOW_US   = 100;
   localparam int TIMEOUT_US     = 200;
   localparam int BIT1_THRESH_US = 40;
   localparam int L_CYC          = START_LOW_US * CLK_MHZ;
   localparam int TMO_CYC        = TIMEOUT_US * CLK_MHZ;
   localparam int NEVER          = 2147483647;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       sens = 1'b1;
   logic       data;
   logic       data_oe, busy, valid, err;
   logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
   logic [1:0] err_code;

   // Open-drain line with pull-up: low if either side pulls it low.
   assign data = data_oe ? 1'b0 : sens;

   dht11_frame_rx #(
      .CLK_MHZ(CLK_MHZ), .START_LOW_US(START_LOW_US),
      .TIMEOUT_US(TIMEOUT_US), .BIT1_THRESH_US(BIT1_THRESH_US)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .data(data),
      .data_oe(data_oe), .busy(busy), .valid(valid),
      .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
      .err(err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          total = 0, bad = 0, prints = 0;
   int          oe_lo = -1, oe_hi = -1, busy_lo = -1, busy_hi = -1;
   int          strobe_cyc = NEVER, start_cyc = 0;
   bit          strobe_err = 1'b0;
   logic [1:0]  strobe_code = 2'd0, exp_code = 2'd0;
   logic [31:0] pend = 32'd0, cur = 32'd0;
   int          oe_cnt = 0, valid_cnt = 0, err_cnt = 0, rel_cyc = 0, err_cyc = 0;
   bit          prev_oe = 1'b0;

   function automatic bit frame_ok(input logic [39:0] f);
`ifdef DHT11_CHECKSUM_EN
      logic [7:0] s;
      s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      return (s == f[7:0]);
`else
      return 1'b1;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic check_cycle();
      logic [36:0] want, got;
      bit e_oe, e_busy, e_valid, e_err;
      if (rst) begin
         cur      = 32'd0;
         exp_code = 2'd0;
      end else begin
         if (cyc == busy_lo) exp_code = 2'd0;
         if (cyc == strobe_cyc) begin
            exp_code = strobe_code;
            if (!strobe_err) cur = pend;
         end
      end
      e_oe    = !rst && (cyc >= oe_lo) && (cyc < oe_hi);
      e_busy  = !rst && (cyc >= busy_lo) && (cyc < busy_hi);
      e_valid = !rst && (cyc == strobe_cyc) && !strobe_err;
      e_err   = !rst && (cyc == strobe_cyc) && strobe_err;
      want = {e_oe, e_busy, e_valid, e_err, exp_code, cur};
      got  = {data_oe, busy, valid, err, err_code, hum_int, hum_dec, temp_int, temp_dec};
      total++;
      if (got !== want) begin
         bad++;
         if (prints < 20) $display("FAIL cycle %0d outputs: got %h want %h", cyc, got, want);
         prints++;
      end
      if (data_oe) oe_cnt++;
      if (prev_oe && !data_oe) rel_cyc = cyc;
      prev_oe = data_oe;
      if (valid) valid_cnt++;
      if (err) begin
         err_cnt++;
         err_cyc = cyc;
      end
   endtask

   task automatic wait_us(input int n);
      repeat (n * CLK_MHZ) @(negedge clk);
   endtask

   task automatic do_start();
      @(negedge clk);
      start      = 1'b1;
      start_cyc  = cyc + 1;
      busy_lo    = start_cyc;
      busy_hi    = NEVER;
      oe_lo      = start_cyc;
      oe_hi      = start_cyc + L_CYC;
      strobe_cyc = NEVER;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Sensor side of one transaction; optional stuck-high bit, reset at a bit, or a start poke while busy.
   task automatic sensor(input logic [39:0] frame, input int hi0, input int hi1,
                         input int stuck_bit, input int rst_bit, input bit poke);
      int n;
      n = 0;
      while (data_oe !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("release_wait", {31'd0, (n < 2000)}, 32'd1);
      wait_us(30);
      sens = 1'b0;
      if (poke) begin
         wait_us(40);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (40 * CLK_MHZ - 1) @(negedge clk);
      end else begin
         wait_us(80);
      end
      sens = 1'b1;
      wait_us(80);
      for (int i = 0; i < 40; i++) begin
         if (i == rst_bit) begin
            rst     = 1'b1;
            busy_hi = cyc + 1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            return;
         end
         sens = 1'b0;
         wait_us(50);
         sens = 1'b1;
         if (i == stuck_bit) begin
            strobe_cyc  = cyc + 3 + TMO_CYC;
            busy_hi     = strobe_cyc;
            strobe_err  = 1'b1;
            strobe_code = 2'd3;
            wait_us(250);
            sens = 1'b0;
            wait_us(50);
            sens = 1'b1;
            return;
         end
         wait_us(frame[39 - i] ? hi1 : hi0);
      end
      sens        = 1'b0;
      strobe_cyc  = cyc + 4;
      busy_hi     = strobe_cyc;
      strobe_err  = !frame_ok(frame);
      strobe_code = strobe_err ? 2'd2 : 2'd0;
      pend        = frame[39:8];
      wait_us(50);
      sens = 1'b1;
   endtask

   initial begin
      int vc, ec;
      fork
         forever begin
            @(posedge clk);
            #1;
            check_cycle();
         end
      join_none

      // Reset with a coincident start that must be dropped.
      rst   = 1'b1;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (100) @(negedge clk);
      check("idle_oe", {31'd0, data_oe}, 32'd0);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_bytes", {hum_int, hum_dec, temp_int, temp_dec}, 32'h0000_0000);
      check("idle_code", {30'd0, err_code}, 32'd0);

      // Good frame, with a start poked mid-transaction.
      oe_cnt    = 0;
      valid_cnt = 0;
      do_start();
      sensor(40'h37_00_18_05_54, 26, 70, -1, -1, 1'b1);
      repeat (20) @(negedge clk);
      check("a_oe_cycles", oe_cnt, 32'd200);
      check("a_valid_cnt", valid_cnt, 32'd1);
      check("a_hum_int", {24'd0, hum_int}, 32'h37);
      check("a_temp_int", {24'd0, temp_int}, 32'h18);
      check("a_temp_dec", {24'd0, temp_dec}, 32'h05);

      // Frame with a wrong checksum byte.
      vc = valid_cnt;
      ec = err_cnt;
      do_start();
      sensor(40'h41_02_1A_03_61, 26, 70, -1, -1, 1'b0);
      repeat (20) @(negedge clk);
`ifdef DHT11_CHECKSUM_EN
      check("b_err_cnt", err_cnt - ec, 32'd1);
      check("b_code", {30'd0, err_code}, 32'd2);
      check("b_hum_int", {24'd0, hum_int}, 32'h37);
`else
      check("b_valid_cnt", valid_cnt - vc, 32'd1);
      check("b_code", {30'd0, err_code}, 32'd0);
      check("b_hum_int", {24'd0, hum_int}, 32'h41);
`endif

      // Silent sensor: no response after release.
      do_start();
      strobe_cyc  = start_cyc + L_CYC + TMO_CYC;
      busy_hi     = strobe_cyc;
      strobe_err  = 1'b1;
      strobe_code = 2'd1;
      repeat (L_CYC + TMO_CYC + 20) @(negedge clk);
      check("silent_code", {30'd0, err_code}, 32'd1);
      check("silent_delay", err_cyc - rel_cyc, 32'd400);
      check("silent_busy", {31'd0, busy}, 32'd0);

      // Bit-high of exactly 40 us decodes 0, 41 us decodes 1.
      do_start();
      sensor(40'hA5_5A_0F_F0_FE, 40, 41, -1, -1, 1'b0);
      repeat (20) @(negedge clk);
      check("edge_bytes", {hum_int, hum_dec, temp_int, temp_dec}, 32'hA55A_0FF0);
      check("edge_code", {30'd0, err_code}, 32'd0);

      // Bit high stuck for 250 us.
      do_start();
      sensor(40'h12_34_56_78_14, 26, 70, 5, -1, 1'b0);
      repeat (20) @(negedge clk);
      check("stuck_code", {30'd0, err_code}, 32'd3);
      check("stuck_hum_int", {24'd0, hum_int}, 32'hA5);

      // Reset at bit 20, then a fresh frame whose checksum wraps past 0xFF.
      do_start();
      sensor(40'h12_34_56_78_14, 26, 70, -1, 20, 1'b0);
      check("rst_oe", {31'd0, data_oe}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_bytes", {hum_int, hum_dec, temp_int, temp_dec}, 32'h0000_0000);
      repeat (200) @(negedge clk);
      do_start();
      sensor(40'h12_34_56_78_14, 26, 70, -1, -1, 1'b0);
      repeat (20) @(negedge clk);
      check("c_bytes", {hum_int, hum_dec, temp_int, temp_dec}, 32'h1234_5678);
      check("c_code", {30'd0, err_code}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dht11_frame_rx.md
# dht11_frame_rx

Single-wire DHT11 host front end that issues the start pulse, times the sensor's response and 40 data bits, and delivers humidity/temperature bytes to the downstream capture/display stage. It owns the bidirectional data line as an open-drain driver and hands the consumer a one-cycle `valid` strobe with stable bytes. It sits directly upstream of the temperature/humidity capture logic.

## Interface
- `CLK_MHZ`, 50, system clock frequency in MHz; sets the 1 µs tick prescaler.
- `START_LOW_US`, 18000, host start pulse length in µs.
- `TIMEOUT_US`, 200, maximum duration of any single sensor-driven phase before abort.
- `BIT1_THRESH_US`, 40, bit-high durations strictly greater than this decode as 1.
- `clk` in 1: single system clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle request to read a frame; ignored while `busy`.
- `data` in 1: raw sampled level of the DHT11 line (asynchronous).
- `data_oe` out 1: 1 = drive line low, 0 = release (pull-up).
- `busy` out 1: high from accepted `start` until `valid` or `err`.
- `valid` out 1: one-cycle strobe; byte outputs updated same cycle.
- `hum_int`, `hum_dec`, `temp_int`, `temp_dec` out 8 each: last good frame.
- `err` out 1: one-cycle abort strobe.
- `err_code` out 2: 0 none, 1 no response, 2 checksum mismatch, 3 bit/phase timeout; held until next accepted `start`.

## Operation
- `data` passes a 2-FF synchronizer; all decoding uses the synchronized level and its edges.
- 1 µs tick from a mod-`CLK_MHZ` prescaler, reset on every state entry; µs counter 15 bits, saturating.
- States: IDLE → START_LOW (`data_oe`=1 for `START_LOW_US`) → WAIT_RESP (released; wait sensor low, limit `TIMEOUT_US`, else code 1) → RESP_LOW (wait rising) → RESP_HIGH (wait falling) → BIT_LOW (wait rising) → BIT_HIGH (measure µs until falling) → BIT_LOW or CHECK after 40th bit → IDLE.
- RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH exceeding `TIMEOUT_US` → code 3.
- Bit decision on falling edge ending BIT_HIGH: count > `BIT1_THRESH_US` → 1; exactly 40 → 0. Shifted MSB-first into a 40-bit register, 6-bit bit counter 0..40.
- Frame byte order: hum_int, hum_dec, temp_int, temp_dec, checksum.
- CHECK: checksum = (sum of first four bytes) mod 256, 8-bit wrap.
- On error: `data_oe`=0, `err` pulse, byte outputs unchanged, return to IDLE.
- Reset values: `data_oe`=0, `busy`=0, `valid`=0, `err`=0, `err_code`=0, all bytes 0x00, state IDLE.

## Timing
- `start` accepted in IDLE: `busy` and `data_oe` rise the next cycle.
- `valid` (or `err` code 2) asserts 1 cycle after CHECK entry; CHECK entered the cycle after the synchronized falling edge of bit 40 (≈3 clk after the raw edge).
- `busy` falls in the same cycle `valid`/`err` is high; new `start` accepted the following cycle.
- `start` coincident with `rst`: reset wins, request dropped.
- `rst` mid-frame: line released next edge, partial frame discarded, outputs to reset values.
- `start` while busy: ignored, no queuing.

## Configuration
- `DHT11_CHECKSUM_EN` defined: CHECK compares checksum; mismatch → `err`, code 2, bytes not updated.
- Undefined: checksum byte received but ignored; every complete 40-bit frame produces `valid`, code 2 never raised.

## Test plan
- Reset then idle 100 cycles → `data_oe`=0, `busy`=0, all bytes 0x00, `err_code`=0.
- `start`, sensor model sends 0x37,0x00,0x18,0x05,0x54 → `data_oe` low exactly 18000 µs, one `valid`, hum_int=0x37, temp_int=0x18, temp_dec=0x05.
- Same frame with checksum 0x55 → `DHT11_CHECKSUM_EN` set: `err`, code 2, bytes keep prior values; unset: `valid` with new bytes.
- Sensor silent after release → `err` with code 1 at 200 µs after release; `busy` falls same cycle.
- Bit-high of exactly 40 µs and 41 µs → decoded 0 and 1; high stuck 250 µs → `err` code 3.
- `rst` asserted at bit 20, then fresh `start` → `data_oe` released next edge, outputs zero, second frame decodes correctly.
